// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO that can use all DEPTH entries. It reports
// occupancy, almost-full/almost-empty against fixed thresholds, and sticky
// overflow/underflow flags. It also has a synchronous clear and a read-valid
// strobe.
//
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
// In that mode data_out presents the head word combinationally and
// rd_valid = !empty. When the macro is undefined, data_out is registered with
// 1-cycle latency and rd_valid pulses once per popped word.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous clear (pointers, read output, error flags)
//   w_en/data_in write request and data
//   r_en         read request
//   data_out     read data
//   rd_valid     data_out carries a popped word
//   full/empty/almost_full/almost_empty/count  occupancy status
//   overflow/underflow                         sticky error flags
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     r_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wr_accept;
  logic                  rd_accept;

  // The extra MSB on each pointer tells a full FIFO apart from an empty one,
  // so a plain modular difference gives the occupancy 0..DEPTH.
  assign count        = wr_ptr_reg - rd_ptr_reg;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Clear wins over both requests, so nothing is accepted during clr.
  assign wr_accept = w_en && !full && !clr;
  assign rd_accept = r_en && !empty && !clr;

  // Storage is not reset; contents only matter between the pointers.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (w_en && full) begin
        overflow_reg <= 1'b1;
      end
      if (r_en && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; its value is meaningless while empty.
  assign data_out = mem[rd_ptr_reg[AW-1:0]];
  assign rd_valid = !empty;
`else
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  rd_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else if (clr) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        data_out_reg <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

  assign data_out = data_out_reg;
  assign rd_valid = rd_valid_reg;
`endif

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO and the successor to the basic single-clock FIFO. It adds:
- full-depth usage via an extra pointer wrap bit
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous clear
- a read-valid strobe

It sits between a producer and a consumer in the same clock domain, for example a packet ingress buffer ahead of a processing pipeline.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; power of 2, 2 or more
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: empties the FIFO and clears the error flags
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read request
data_out  out  DATA_WIDTH  read data (registered)
rd_valid  out  1  data_out holds a newly popped word this cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: pointers 0, data_out 0, rd_valid 0, overflow 0, underflow 0. The flags then read empty=1, full=0, count=0, almost_empty=1, almost_full=0.
- Pointers:
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - All DEPTH entries are usable.
  - The storage array is not reset.
- Status flags: full, empty, almost_full, almost_empty and count are combinational from the registered pointers. They update the cycle after the accepting edge.
- Write accept: w_en && !full, evaluated on pre-edge state. On accept, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accept (standard mode): r_en && !empty. On accept, data_out <= mem[rd_ptr], rd_ptr increments, and rd_valid=1 for exactly one cycle.
  - Latency is 1 cycle from the accepting edge.
  - Without an accept, data_out holds its value and rd_valid=0.
- Simultaneous read and write:
  - Each is accepted independently on pre-edge flags; count is unchanged if both are accepted.
  - When full, the write is rejected even if a read is accepted that same cycle.
  - When empty, the read is rejected even if a write is accepted that same cycle.
- Rejected requests change no state.
  - w_en && full sets overflow.
  - r_en && empty sets underflow.
  - Both flags stay set until clr or reset.
- clr:
  - Resets pointers, data_out, rd_valid and both sticky flags on the next edge.
  - It has priority over w_en and r_en in the same cycle; neither request is accepted and neither sets an error flag.
- Wrap-around: pointers wrap naturally. Ordering and count stay correct across any number of wraps.
- Reset mid-operation: all contents are discarded immediately. Outputs take their reset values asynchronously.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - data_out continuously presents mem[rd_ptr] whenever !empty; it is 0-latency and reflects the head word.
  - rd_valid = !empty, combinational.
  - r_en && !empty pops the head; the next word appears after the edge.
  - data_out is don't-care while empty.
  - Flags, count, clr and the error flags are identical to standard mode.
- Undefined: standard registered-read mode as described in Behaviour.

Test Plan:
1. Reset, then write 0x01..0x10 (16 words, DEPTH=16) -> full=1 and count=16 after the 16th edge; almost_full=1 from count=12. Then read 16 -> data_out 0x01..0x10 in order, each with a rd_valid pulse; empty=1 at the end.
2. Fill to 16, then hold w_en=1 with data 0xAA -> overflow=1; count stays 16; 0xAA never appears at the output. Empty the FIFO, then read once more -> underflow=1.
3. Hold count at 8, then assert w_en and r_en together for 20 cycles with incrementing data -> count stays 8 and the output sequence is strictly in order across the pointer wrap.
4. Put 5 words in, set overflow via a full condition from a prior fill, then assert clr together with w_en and r_en -> next cycle count=0, empty=1, overflow=0, underflow=0, rd_valid=0.
5. Write 3 words, then drop rst_n asynchronously mid-cycle -> empty=1, count=0, data_out=0 without waiting for a clock edge. Then write 0x55 and read it -> data_out=0x55.
6. With SYNC_FIFO_FWFT_EN defined, write 0x3C -> data_out=0x3C and rd_valid=1 the cycle after the write, with no r_en. Pulse r_en -> empty=1 on the next cycle.
